// File: rtl/cpu_stack_pkg.sv
// Constants and the PC type shared by the CPU datapath, controller and return-address stack.
package cpu_stack_pkg;
    localparam int RAS_DEPTH = 8;
    localparam int PC_W      = 12;

    typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/ras_regfile.sv
// Return-address storage: one synchronous write port and one combinational read port.
module ras_regfile
    import cpu_stack_pkg::*;
#(
    parameter int AW    = PC_W,
    parameter int DEPTH = RAS_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [DEPTH];

    // No reset: contents are only ever read through a valid stack pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with combinational top read and sticky overflow/underflow flags.
module ret_addr_stack
    import cpu_stack_pkg::*;
#(
    parameter int AW    = PC_W,
    parameter int DEPTH = RAS_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data,
    output logic [PW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] sp, sp_nxt, top_ptr;
    logic [PW:0]   count_nxt;
    logic          overflow_nxt, underflow_nxt;
    logic          we;
    logic [PW-1:0] waddr;
    logic [AW-1:0] rdata;

    assign top_ptr = sp - PW'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);

    always_comb begin
        sp_nxt        = sp;
        count_nxt     = count;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;
        we            = 1'b0;
        waddr         = sp;
        if (clr) begin
            sp_nxt        = '0;
            count_nxt     = '0;
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end else if (push && pop && !empty) begin
            we    = 1'b1;
            waddr = top_ptr;
        end else if (push) begin
            // Push on a full stack overwrites the oldest entry via pointer wrap.
            we     = 1'b1;
            sp_nxt = sp + PW'(1);
            if (full) begin
                overflow_nxt = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                underflow_nxt = 1'b1;
            end else begin
                sp_nxt    = top_ptr;
                count_nxt = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    ras_regfile #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (top_ptr),
        .rdata (rdata)
    );

    assign top_data = empty ? '0 : rdata;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: queue-based LIFO model checked every cycle, plus directed literal checks.
module tb_ret_addr_stack;
    import cpu_stack_pkg::*;

    localparam int D = RAS_DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    pc_t         push_data = '0;
    pc_t         top_data;
    logic [3:0]  count;
    logic        empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    pc_t m_q[$];
    bit  m_ovf = 1'b0;
    bit  m_unf = 1'b0;

    always #5 clk = ~clk;

    ret_addr_stack dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top_data  (top_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Reference: a bounded LIFO where a push into a full stack drops the oldest entry.
    always @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (push && pop && m_q.size() > 0) begin
            m_q[m_q.size()-1] = push_data;
        end else if (push) begin
            if (m_q.size() == D) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
            m_q.push_back(push_data);
        end else if (pop) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else void'(m_q.pop_back());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            pc_t exp_top;
            exp_top = (m_q.size() == 0) ? pc_t'(0) : m_q[m_q.size()-1];
            chk("cmp_top", 32'(top_data), 32'(exp_top));
            chk("cmp_count", 32'(count), 32'(m_q.size()));
            chk("cmp_empty", 32'(empty), 32'(m_q.size() == 0));
            chk("cmp_full", 32'(full), 32'(m_q.size() == D));
            chk("cmp_ovf", 32'(overflow), 32'(m_ovf));
            chk("cmp_unf", 32'(underflow), 32'(m_unf));
        end
    end

    // Drive strobes for one clock edge; returns at the following negedge.
    task automatic cyc(input bit pu, input bit po, input pc_t d, input bit c);
        push = pu;
        pop = po;
        push_data = d;
        clr = c;
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        pc_t pc;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_cmp = 1'b1;
        chk("rst_top", 32'(top_data), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);

        // Empty pop
        cyc(0, 1, '0, 0);
        chk("upop_top", 32'(top_data), 0);
        chk("upop_count", 32'(count), 0);
        chk("upop_unf", 32'(underflow), 1);
        chk("upop_empty", 32'(empty), 1);
        cyc(0, 0, '0, 1);
        chk("clr_unf", 32'(underflow), 0);

        // LIFO order
        cyc(1, 0, 12'h010, 0);
        cyc(1, 0, 12'h020, 0);
        cyc(1, 0, 12'h030, 0);
        chk("ord_top", 32'(top_data), 32'h030);
        chk("ord_count", 32'(count), 3);
        for (int i = 0; i < 3; i++) begin
            chk("ord_pop_top", 32'(top_data), 32'(12'h030 - 12'h010 * i));
            cyc(0, 1, '0, 0);
        end
        chk("ord_empty", 32'(empty), 1);
        chk("ord_top0", 32'(top_data), 0);

        // Overflow wrap
        for (int i = 0; i <= 8; i++) cyc(1, 0, pc_t'(12'h100 + i), 0);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_top", 32'(top_data), 32'h108);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_pop_top", 32'(top_data), 32'(12'h108 - i));
            cyc(0, 1, '0, 0);
        end
        chk("ovf_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);
        cyc(0, 0, '0, 1);
        chk("ovf_clr", 32'(overflow), 0);

        // Simultaneous push and pop
        cyc(1, 0, 12'h0AA, 0);
        cyc(1, 1, 12'h0BB, 0);
        chk("pp_count", 32'(count), 1);
        chk("pp_top", 32'(top_data), 32'h0BB);
        cyc(0, 1, '0, 0);
        cyc(1, 1, 12'h0CC, 0);
        chk("ppe_count", 32'(count), 1);
        chk("ppe_top", 32'(top_data), 32'h0CC);
        chk("ppe_unf", 32'(underflow), 0);
        cyc(0, 0, '0, 1);

        // Async reset mid-sequence with strobes held
        cyc(1, 0, 12'h111, 0);
        cyc(1, 0, 12'h222, 0);
        cyc(1, 0, 12'h333, 0);
        chk("ar_pre", 32'(count), 3);
        #2;
        push = 1'b1;
        pop = 1'b0;
        push_data = 12'h777;
        rst = 1'b0;
        #1;
        chk("ar_async_count", 32'(count), 0);
        chk("ar_async_empty", 32'(empty), 1);
        @(negedge clk);
        @(negedge clk);
        chk("ar_held_count", 32'(count), 0);
        push = 1'b0;
        #2;
        rst = 1'b1;
        cyc(1, 0, 12'h0E1, 0);
        chk("ar_after_count", 32'(count), 1);
        chk("ar_after_top", 32'(top_data), 32'h0E1);
        cyc(0, 0, '0, 1);

        // Controller co-simulation: call 0x040 from PC 0x005, then return
        pc = 12'h005;
        push = 1'b1;
        push_data = pc + 12'h001;
        @(posedge clk);
        pc = 12'h040;
        @(negedge clk);
        push = 1'b0;
        pop = 1'b1;
        @(posedge clk);
        pc = top_data;
        #1;
        pop = 1'b0;
        chk("cpu_ret_pc", 32'(pc), 32'h006);
        @(negedge clk);
        chk("cpu_empty", 32'(empty), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r < 50 || (r >= 85 && r < 97), (r >= 45 && r < 97),
                pc_t'($urandom), (r >= 97));
        end

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
